instr_mem: RTL
==============

# instr_mem

Parametrised, pipelined instruction memory for the milano core's fetch stage. Replaces the combinational, asynchronous-read instruction ROM with synchronous storage behind a req/gnt/rvalid fetch handshake. Adds configurable read latency with back-to-back pipelined fetches, flush of in-flight responses on redirect, and a loader write port so programs are written at run time rather than baked in.

## Interface
Parameters:
- DEPTH, 2048: number of DATA_W-bit words; power of two, ≥ 2.
- DATA_W, 32: instruction word width.
- LATENCY, 1: cycles from grant to rvalid; legal range 1..4.
- IDX_W, $clog2(DEPTH): word-index width (derived, not overridden).

Ports:
- clk_i  in  1  core clock; all state on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- instr_req_i  in  1  fetch request.
- instr_addr_i  in  32  byte address; word index = addr[IDX_W+1:2].
- instr_gnt_o  out  1  request accepted this cycle (combinational).
- instr_rvalid_o  out  1  response valid.
- instr_rdata_o  out  DATA_W  fetched instruction.
- instr_err_o  out  1  response error, qualified by rvalid.
- flush_i  in  1  discard all responses already in flight.
- ld_we_i  in  1  loader write enable.
- ld_idx_i  in  IDX_W  loader word index.
- ld_wdata_i  in  DATA_W  loader write data.

## Operation
- Grant: instr_gnt_o = instr_req_i & ~ld_we_i. A loader write takes priority; the fetch is held off, with no grant that cycle.
- No stall input. The consumer accepts every rvalid. One request may be granted per cycle, giving up to LATENCY fetches in flight.
- On grant, the array is read synchronously at the word index. Data and error status then pass through a LATENCY-stage valid/data/err shift pipeline.
- Loader write: mem[ld_idx_i] <= ld_wdata_i on any cycle with ld_we_i = 1.
  - A fetch granted before the write returns the old data, because the read was sampled at grant.
  - A fetch granted after the write returns the new data.
- Flush: when flush_i = 1, every stage's valid bit clears on that edge.
  - A request granted in the same cycle as flush_i is kept. It is the redirect target.
  - A flush with nothing in flight is a no-op.
- Error checking (see Configuration) compares the addr bits above IDX_W+1 against zero, and checks addr[1:0] against zero.
- On an error response, instr_rdata_o = 0.
- Memory contents are not reset and are X until loaded.

## Timing
- Reset values: instr_rvalid_o = 0, instr_rdata_o = 0, instr_err_o = 0, all pipeline valid bits 0. instr_gnt_o follows its inputs, even during reset.
- Request granted at edge T gives instr_rvalid_o high for exactly one cycle after edge T+LATENCY.
- Back-to-back grants at T, T+1, T+2 give responses in order at T+L, T+L+1, T+L+2. There is no reordering and no bubbles.
- Flush asserted at edge F:
  - Every response that would have appeared after F is suppressed.
  - A grant taken at F appears at F+LATENCY.
- Reset asserted mid-operation clears all in-flight responses immediately (asynchronously). The first grant is possible on the first edge after rst_i deasserts.
- LATENCY = 1 means the registered array output drives the outputs directly, with no extra stages.

## Configuration
- INSTR_MEM_ERR_EN defined:
  - Out-of-range or misaligned fetch addresses are still granted and still take LATENCY cycles.
  - Their response has instr_err_o = 1 and instr_rdata_o = 0.
- INSTR_MEM_ERR_EN undefined:
  - Upper and low address bits are ignored, so the index wraps modulo DEPTH.
  - instr_err_o is tied to 0 and no error logic is generated.

## Structure
- Package instr_mem_pkg holds:
  - LATENCY_MAX = 4.
  - A typedef for the pipeline stage struct {valid, err, data}.
  - Localparams for the byte-offset width (2) and the default DEPTH.
- Sub-module instr_mem_array is a single-port synchronous RAM: one write port, one registered read port, write-first not required. It keeps the storage inferable as block RAM.
- instr_mem contains the grant logic, error check, flush and latency pipeline.

## Test plan
- Reset then load, LATENCY=2:
  - Write mem[0..3] = 0x13, 0x93, 0x113, 0x193.
  - Fetch addr 0x0,0x4,0x8,0xC back-to-back.
  - Expect rvalid on 4 consecutive cycles starting 2 cycles after the first grant, data in order.
- Loader priority:
  - ld_we_i=1 with instr_req_i=1 gives instr_gnt_o=0 that cycle. The fetch is granted the next cycle.
  - A fetch of the same index returns the new word.
- Read-before-write ordering:
  - Grant a fetch of idx 5 (old 0xAAAA_AAAA), then write idx 5 = 0xBBBB_BBBB on the next cycle.
  - Response is 0xAAAA_AAAA. A later fetch returns 0xBBBB_BBBB.
- Flush, LATENCY=3:
  - Grants at T, T+1, then flush_i with a new grant to 0x40 at T+2.
  - Only the 0x40 response appears, at T+5.
- Errors with INSTR_MEM_ERR_EN, DEPTH=2048:
  - Fetch 0x0000_2000 gives err=1, rdata=0.
  - Fetch 0x2 gives err=1.
  - Without the macro, 0x0000_2000 returns mem[0] with err=0.
- Async reset with 3 responses in flight: rvalid drops immediately, and no stale response appears after release.

Source files
------------

// File: rtl/instr_mem_pkg.sv
// Shared constants and stage layout for the pipelined instruction memory.
package instr_mem_pkg;

    localparam int LATENCY_MAX = 4;
    localparam int BYTE_OFF_W  = 2;
    localparam int DEPTH_DEF   = 2048;
    localparam int DATA_W_DEF  = 32;

    // Canonical response-stage layout at the default instruction width.
    typedef struct packed {
        logic                  valid;
        logic                  err;
        logic [DATA_W_DEF-1:0] data;
    } stage_t;

endpackage

// File: rtl/instr_mem_array.sv
// Single-port synchronous RAM: one write or one registered read per cycle.
// Read data holds until the next read; no reset so it maps onto block RAM.
module instr_mem_array #(
    parameter int DEPTH  = 2048,
    parameter int DATA_W = 32,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[idx_i] <= wdata_i;
            end else begin
                rdata_q <= mem_q[idx_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/instr_mem.sv
// Pipelined instruction memory: req/gnt/rvalid fetch, LATENCY-cycle response, flush, loader port.
// Define INSTR_MEM_ERR_EN to flag out-of-range or misaligned fetch addresses.
module instr_mem
    import instr_mem_pkg::*;
#(
    parameter int  DEPTH   = DEPTH_DEF,
    parameter int  DATA_W  = DATA_W_DEF,
    parameter int  LATENCY = 1,
    localparam int IDX_W   = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              instr_req_i,
    input  logic [31:0]       instr_addr_i,
    output logic              instr_gnt_o,
    output logic              instr_rvalid_o,
    output logic [DATA_W-1:0] instr_rdata_o,
    output logic              instr_err_o,
    input  logic              flush_i,
    input  logic              ld_we_i,
    input  logic [IDX_W-1:0]  ld_idx_i,
    input  logic [DATA_W-1:0] ld_wdata_i
);

    logic               gnt;
    logic [IDX_W-1:0]   fetch_idx;
    logic               fetch_err;
    logic [DATA_W-1:0]  arr_rdata;
    logic [DATA_W-1:0]  out_dat;
    logic [LATENCY-1:0] vld_q, vld_d;
    logic [LATENCY-1:0] err_q, err_d;

    assign gnt         = instr_req_i & ~ld_we_i;
    assign instr_gnt_o = gnt;
    assign fetch_idx   = instr_addr_i[IDX_W+BYTE_OFF_W-1:BYTE_OFF_W];

`ifdef INSTR_MEM_ERR_EN
    assign fetch_err = (instr_addr_i[31:IDX_W+BYTE_OFF_W] != '0) ||
                       (instr_addr_i[BYTE_OFF_W-1:0] != '0);
`else
    logic unused_addr;
    assign fetch_err   = 1'b0;
    assign unused_addr = ^{instr_addr_i[31:IDX_W+BYTE_OFF_W], instr_addr_i[BYTE_OFF_W-1:0]};
`endif

    // Loader and fetch never share a cycle, so one port serves both.
    instr_mem_array #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk_i   (clk_i),
        .en_i    (gnt | ld_we_i),
        .we_i    (ld_we_i),
        .idx_i   (ld_we_i ? ld_idx_i : fetch_idx),
        .wdata_i (ld_wdata_i),
        .rdata_o (arr_rdata)
    );

    // The new grant always enters stage 0; flush only kills older stages.
    always_comb begin
        vld_d    = vld_q;
        err_d    = err_q;
        vld_d[0] = gnt;
        err_d[0] = fetch_err;
        for (int k = 1; k < LATENCY; k++) begin
            vld_d[k] = vld_q[k-1] & ~flush_i;
            err_d[k] = err_q[k-1];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q <= '0;
            err_q <= '0;
        end else begin
            vld_q <= vld_d;
            err_q <= err_d;
        end
    end

    generate
        if (LATENCY == 1) begin : g_lat1
            assign out_dat = arr_rdata;
        end else begin : g_latn
            logic [DATA_W-1:0] dat_q [LATENCY-1];

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    for (int k = 0; k < LATENCY-1; k++) dat_q[k] <= '0;
                end else begin
                    dat_q[0] <= arr_rdata;
                    for (int k = 1; k < LATENCY-1; k++) dat_q[k] <= dat_q[k-1];
                end
            end

            assign out_dat = dat_q[LATENCY-2];
        end
    endgenerate

    assign instr_rvalid_o = vld_q[LATENCY-1];
    assign instr_err_o    = vld_q[LATENCY-1] & err_q[LATENCY-1];
    assign instr_rdata_o  = (vld_q[LATENCY-1] && !err_q[LATENCY-1]) ? out_dat : '0;

endmodule
